aes_key_loader: RTL and testbench

AES_KEY_LOADER -- requirements
Module: aes_key_loader

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_key_beat_cnt.sv | 51 +++++
 rtl/aes_key_loader.sv | 153 +++++++++++++++
 tb/tb_aes_key_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_pkg                                                       |
// | Purpose  : Shared key-length encodings, maximum key width and FSM state  |
// |            type for the AES key loader and its beat counter.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package aes_pkg;

  // Widest key the loader assembles; key_out is always this wide.
  localparam int unsigned c_key_max_w = 256;

  // key_len encodings
  localparam logic [1:0] KEY_LEN_128  = 2'd0;
  localparam logic [1:0] KEY_LEN_192  = 2'd1;
  localparam logic [1:0] KEY_LEN_256  = 2'd2;
  localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Key size in bits for a key_len code; the reserved code never reaches
  // the counter, so it falls back to the smallest key.
  function automatic int unsigned key_bits(input logic [1:0] len);
    case (len)
      KEY_LEN_192: key_bits = 192;
      KEY_LEN_256: key_bits = 256;
      default:     key_bits = 128;
    endcase
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_key_beat_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_key_beat_cnt                                              |
// | Purpose  : Counts accepted key beats and flags the final beat of the     |
// |            current key (keybits / DIN_W beats).                          |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            clr     - restart the count at zero                           |
// |            inc     - one beat accepted this cycle                        |
// |            key_len - latched key size code                               |
// |            last    - the count currently points at the final beat        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module aes_key_beat_cnt
  import aes_pkg::*;
#(
  parameter int DIN_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [1:0] key_len,
  output logic       last
);

  // Wide enough for the longest key at the narrowest beat (256/8 beats).
  localparam int c_cnt_w = $clog2(c_key_max_w / 8) + 1;

  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_last_idx;

  // Index of the final beat: keybits/DIN_W - 1 (folds to constants).
  always_comb begin
    w_last_idx = c_cnt_w'(key_bits(key_len) / DIN_W - 1);
  end

  assign last = (r_cnt == w_last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule : aes_key_beat_cnt
`default_nettype wire

// File: rtl/aes_key_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_key_loader                                                |
// | Purpose  : Assembles a 128/192/256-bit AES key from DIN_W-bit beats,     |
// |            MS beat first, right-aligned in key_out, and hands it off     |
// |            with a valid/ack level handshake.                             |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            start/key_len      - begin a load, latch key size             |
// |            din/din_valid      - key beats in; din_ready high in LOAD     |
// |            key_out/key_valid  - assembled key, held until key_ack        |
// |            key_len_out        - key size of the current key              |
// |            err                - one-cycle pulse on reserved key_len      |
// |            zeroize            - only with AES_KEY_LOADER_ZEROIZE_EN:     |
// |                                 wipe key and return to IDLE              |
// | Config   : `define AES_KEY_LOADER_ZEROIZE_EN adds the zeroize input.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module aes_key_loader
  import aes_pkg::*;
#(
  parameter int DIN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef AES_KEY_LOADER_ZEROIZE_EN
  input  logic                   zeroize,
`endif
  input  logic                   start,
  input  logic [1:0]             key_len,
  input  logic [DIN_W-1:0]       din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [c_key_max_w-1:0] key_out,
  output logic                   key_valid,
  input  logic                   key_ack,
  output logic [1:0]             key_len_out,
  output logic                   err
);

  generate
    if (!(DIN_W == 8 || DIN_W == 16 || DIN_W == 32 || DIN_W == 64)) begin : g_bad_din_w
      $error("aes_key_loader: DIN_W must be 8, 16, 32 or 64");
    end
  endgenerate

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_key_max_w-1:0] r_key;
  logic [1:0]             r_key_len;
  logic                   r_err;
  logic                   w_zeroize;
  logic                   w_start_ok;
  logic                   w_start_bad;
  logic                   w_beat_acc;
  logic                   w_last;
  logic                   w_clr;

`ifdef AES_KEY_LOADER_ZEROIZE_EN
  assign w_zeroize = zeroize;
`else
  assign w_zeroize = 1'b0;
`endif

  // Priority: zeroize > start > beat / ack. A start in any state restarts
  // (or, with a reserved length, aborts to IDLE without touching the key).
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_beat_acc  = 1'b0;
    if (w_zeroize) begin
      w_state_nxt = ST_IDLE;
    end else if (start) begin
      if (key_len == KEY_LEN_RSVD) begin
        w_start_bad = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_start_ok  = 1'b1;
        w_state_nxt = ST_LOAD;
      end
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_LOAD: begin
          if (din_valid) begin
            w_beat_acc = 1'b1;
            if (w_last) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (key_ack) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_clr = w_zeroize | w_start_ok;

  aes_key_beat_cnt #(
    .DIN_W   (DIN_W)
  ) u_beat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .inc     (w_beat_acc),
    .key_len (r_key_len),
    .last    (w_last)
  );

  // The key register doubles as the shift register; it is cleared at start
  // so short keys come out right-aligned with zero upper bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key     <= '0;
      r_key_len <= KEY_LEN_128;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_start_bad;
      if (w_clr) begin
        r_key <= '0;
      end else if (w_beat_acc) begin
        r_key <= {r_key[c_key_max_w-1-DIN_W:0], din};
      end
      if (w_zeroize) begin
        r_key_len <= KEY_LEN_128;
      end else if (w_start_ok) begin
        r_key_len <= key_len;
      end
    end
  end

  assign din_ready   = (r_state == ST_LOAD);
  assign key_valid   = (r_state == ST_DONE);
  assign key_out     = r_key;
  assign key_len_out = r_key_len;
  assign err         = r_err;

endmodule : aes_key_loader
`default_nettype wire

// File: tb/tb_aes_key_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aes_key_loader                                             |
// | Purpose  : Self-checking bench for aes_key_loader. Instance 0 uses       |
// |            DIN_W=8, instance 1 uses DIN_W=32. A beat-list model predicts |
// |            every output each cycle; literal keys pin the model.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_aes_key_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            start, key_ack, din_valid, zeroize;
  logic [1:0][1:0]       key_len;
  logic [1:0][63:0]      din;
  logic [1:0]            din_ready, key_valid, err;
  logic [1:0][255:0]     key_out;
  logic [1:0][1:0]       key_len_out;

  aes_key_loader #(.DIN_W(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_KEY_LOADER_ZEROIZE_EN
    .zeroize     (zeroize[0]),
`endif
    .start       (start[0]),
    .key_len     (key_len[0]),
    .din         (din[0][7:0]),
    .din_valid   (din_valid[0]),
    .din_ready   (din_ready[0]),
    .key_out     (key_out[0]),
    .key_valid   (key_valid[0]),
    .key_ack     (key_ack[0]),
    .key_len_out (key_len_out[0]),
    .err         (err[0])
  );

  aes_key_loader #(.DIN_W(32)) dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_KEY_LOADER_ZEROIZE_EN
    .zeroize     (zeroize[1]),
`endif
    .start       (start[1]),
    .key_len     (key_len[1]),
    .din         (din[1][31:0]),
    .din_valid   (din_valid[1]),
    .din_ready   (din_ready[1]),
    .key_out     (key_out[1]),
    .key_valid   (key_valid[1]),
    .key_ack     (key_ack[1]),
    .key_len_out (key_len_out[1]),
    .err         (err[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h required %h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 collecting beats, 2 key complete. The key is the list
  // of accepted beats concatenated, first beat most significant.
  int          m_phase [2];
  int          m_n     [2];
  int          m_need  [2];
  logic [1:0]  m_len   [2];
  bit          m_err   [2];
  logic [63:0] m_beat  [2][32];

  function automatic int width_of(input int i);
    return (i == 0) ? 8 : 32;
  endfunction

  function automatic logic [255:0] m_key(input int i);
    logic [255:0] k;
    k = '0;
    for (int b = 0; b < m_n[i]; b++) begin
      k = (k << width_of(i)) | 256'(m_beat[i][b]);
    end
    return k;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] = 0; m_n[i] = 0; m_len[i] = 2'd0; m_err[i] = 1'b0; m_need[i] = 16;
      end else begin
        m_err[i] = 1'b0;
        if (zeroize[i]) begin
          m_phase[i] = 0; m_n[i] = 0; m_len[i] = 2'd0;
        end else if (start[i]) begin
          if (key_len[i] == 2'd3) begin
            m_err[i] = 1'b1; m_phase[i] = 0;
          end else begin
            m_n[i]    = 0;
            m_len[i]  = key_len[i];
            m_need[i] = (128 + 64 * int'(key_len[i])) / width_of(i);
            m_phase[i] = 1;
          end
        end else if (m_phase[i] == 1 && din_valid[i]) begin
          m_beat[i][m_n[i]] = din[i] & ((64'd1 << width_of(i)) - 64'd1);
          m_n[i]++;
          if (m_n[i] == m_need[i]) m_phase[i] = 2;
        end else if (m_phase[i] == 2 && key_ack[i]) begin
          m_phase[i] = 0;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d din_ready", i),   256'(din_ready[i]),   256'(m_phase[i] == 1));
        chk($sformatf("i%0d key_valid", i),   256'(key_valid[i]),   256'(m_phase[i] == 2));
        chk($sformatf("i%0d err", i),         256'(err[i]),         256'(m_err[i]));
        chk($sformatf("i%0d key_len_out", i), 256'(key_len_out[i]), 256'(m_len[i]));
        chk($sformatf("i%0d key_out", i),     key_out[i],           m_key(i));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int i, input logic [1:0] len);
    start[i] = 1'b1; key_len[i] = len;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic send(input int i, input int n, input logic [63:0] base, input bit gaps);
    for (int k = 0; k < n; k++) begin
      din[i] = base + 64'(k); din_valid[i] = 1'b1;
      tick();
      if (gaps && (k % 3 == 0)) begin
        din_valid[i] = 1'b0;
        tick();
      end
    end
    din_valid[i] = 1'b0;
  endtask

  localparam logic [255:0] c_k32 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] c_k16 = {128'h0, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf};
  localparam logic [255:0] c_k6  = {64'h0, 192'hc0de0000c0de0001c0de0002c0de0003c0de0004c0de0005};
  localparam logic [255:0] c_k40 =
    256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f;

  initial begin
    start = '0; key_ack = '0; din_valid = '0; zeroize = '0; key_len = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset key_out",     key_out[0], 256'h0);
    chk("reset key_valid",   256'(key_valid[0]), 256'h0);
    chk("reset din_ready",   256'(din_ready[0]), 256'h0);
    chk("reset key_len_out", 256'(key_len_out[0]), 256'h0);
    chk("reset err",         256'(err[0]), 256'h0);
    rst_n = 1'b1;
    tick();

    // 256-bit key, 32 back-to-back beats
    do_start(0, 2'd2);
    send(0, 32, 64'h00, 1'b0);
    chk("k256 key_valid", 256'(key_valid[0]), 256'h1);
    chk("k256 key_out",   key_out[0], c_k32);
    key_ack[0] = 1'b1; tick(); key_ack[0] = 1'b0;
    chk("k256 ack valid low", 256'(key_valid[0]), 256'h0);
    chk("k256 retained",      key_out[0], c_k32);

    // 128-bit key with din_valid gaps
    do_start(0, 2'd0);
    send(0, 16, 64'ha0, 1'b1);
    chk("k128 key_out",     key_out[0], c_k16);
    chk("k128 key_len_out", 256'(key_len_out[0]), 256'h0);

    // reserved key_len while DONE, with a stray beat offered
    start[0] = 1'b1; key_len[0] = 2'd3; din_valid[0] = 1'b1; din[0] = 64'h55;
    tick();
    start[0] = 1'b0; din_valid[0] = 1'b0;
    chk("rsvd err",       256'(err[0]), 256'h1);
    chk("rsvd din_ready", 256'(din_ready[0]), 256'h0);
    chk("rsvd key_out",   key_out[0], c_k16);
    tick();
    chk("rsvd err pulse", 256'(err[0]), 256'h0);
    chk("rsvd key_out2",  key_out[0], c_k16);

    // DIN_W=32, 192-bit key, ack held off 5 cycles
    do_start(1, 2'd1);
    send(1, 6, 64'hc0de0000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("k192 hold valid", 256'(key_valid[1]), 256'h1);
      chk("k192 hold key",   key_out[1], c_k6);
      tick();
    end
    key_ack[1] = 1'b1; tick(); key_ack[1] = 1'b0;
    chk("k192 ack valid low", 256'(key_valid[1]), 256'h0);
    chk("k192 retained",      key_out[1], c_k6);
    chk("k192 key_len_out",   256'(key_len_out[1]), 256'h1);

    // restart after 10 beats; restart cycle also offers a beat
    do_start(0, 2'd2);
    send(0, 10, 64'he0, 1'b0);
    start[0] = 1'b1; key_len[0] = 2'd2; din[0] = 64'hff; din_valid[0] = 1'b1;
    tick();
    start[0] = 1'b0; din_valid[0] = 1'b0;
    send(0, 32, 64'h40, 1'b0);
    chk("restart key_out", key_out[0], c_k40);

    // start in DONE acts as ack plus restart
    do_start(0, 2'd1);
    chk("done-start valid", 256'(key_valid[0]), 256'h0);
    chk("done-start ready", 256'(din_ready[0]), 256'h1);
    chk("done-start key",   key_out[0], 256'h0);

    // asynchronous reset mid-load
    send(0, 5, 64'h10, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("async rst key_out",   key_out[0], 256'h0);
    chk("async rst din_ready", 256'(din_ready[0]), 256'h0);
    chk("async rst key_valid", 256'(key_valid[0]), 256'h0);
    chk("async rst len",       256'(key_len_out[0]), 256'h0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef AES_KEY_LOADER_ZEROIZE_EN
    // zeroize in DONE, with a simultaneous start it must override
    do_start(1, 2'd2);
    send(1, 8, 64'h01020300, 1'b0);
    chk("zz pre valid", 256'(key_valid[1]), 256'h1);
    zeroize[1] = 1'b1; start[1] = 1'b1; key_len[1] = 2'd0;
    tick();
    zeroize[1] = 1'b0; start[1] = 1'b0;
    chk("zz key_out",   key_out[1], 256'h0);
    chk("zz key_valid", 256'(key_valid[1]), 256'h0);
    chk("zz din_ready", 256'(din_ready[1]), 256'h0);
    chk("zz len",       256'(key_len_out[1]), 256'h0);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_aes_key_loader
`default_nettype wire
